trace_frame_encoder: RTL and testbench

- Sits between the packet splitter's byte output (DataAvail/DataVal/DataNext) and the UART transmitter (transmit/tx_byte/tx_free).
- Wraps the raw trace byte stream into HDLC-style framed records so the host can resynchronise after UART loss: an opening flag, byte-stuffed payload, optional CRC, and a closing flag.
- Frames close early when upstream goes idle, so trace latency stays bounded.

---
 rtl/trace_frame_encoder.sv | 181 ++++++++++++++++++
 tb/tb_trace_frame_encoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_frame_encoder.sv
// HDLC-style framer between the trace packet splitter and the UART transmitter.
// Optional build macro TRACE_FRAME_CRC_EN appends a stuffed CRC-16/CCITT-FALSE before the closing flag.
module trace_frame_encoder #(
  parameter int unsigned FRAME_LEN    = 16,
  parameter int unsigned IDLE_TIMEOUT = 4800,
  parameter logic [7:0]  FLAG         = 8'h7E,
  parameter logic [7:0]  ESC          = 8'h7D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DataAvail,
  input  logic [7:0]  DataVal,
  output logic        DataNext,
  input  logic        tx_free,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StOpen,
    StFetch,
    StEsc2,
    StTail,
`ifdef TRACE_FRAME_CRC_EN
    StCrcHi,
    StCrcLo,
`endif
    StClose
  } state_e;

  localparam logic [7:0]  FrameLen    = 8'(FRAME_LEN);
  localparam logic [15:0] IdleTimeout = 16'(IDLE_TIMEOUT);

  state_e      state_q, ret_q;
  logic [7:0]  hold_q;
  logic [7:0]  pay_cnt_q;
  logic [15:0] idle_cnt_q;
  logic        emit_ok;

  // One idle cycle between loads covers the UART's tx_free deassert latency.
  assign emit_ok = tx_free && !transmit;

  function automatic logic is_special(input logic [7:0] b);
    return (b == FLAG) || (b == ESC);
  endfunction

`ifdef TRACE_FRAME_CRC_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ret_q      <= StFetch;
      hold_q     <= 8'h00;
      pay_cnt_q  <= 8'h00;
      idle_cnt_q <= 16'h0000;
      DataNext   <= 1'b0;
      transmit   <= 1'b0;
      tx_byte    <= 8'h00;
      busy       <= 1'b0;
      frame_cnt  <= 16'h0000;
`ifdef TRACE_FRAME_CRC_EN
      crc_q      <= 16'h0000;
`endif
    end else begin
      DataNext <= 1'b0;
      transmit <= 1'b0;
      case (state_q)
        StIdle: begin
          if (DataAvail) begin
            state_q    <= StOpen;
            busy       <= 1'b1;
            pay_cnt_q  <= 8'h00;
            idle_cnt_q <= 16'h0000;
          end
        end
        StOpen: begin
          if (emit_ok) begin
            transmit <= 1'b1;
            tx_byte  <= FLAG;
            state_q  <= StFetch;
`ifdef TRACE_FRAME_CRC_EN
            crc_q    <= 16'hFFFF;
`endif
          end
        end
        StFetch: begin
          // Timeout takes priority over a byte arriving in the same cycle.
          if (pay_cnt_q != 8'h00 && idle_cnt_q >= IdleTimeout) begin
            state_q <= StTail;
          end else if (DataAvail) begin
            if (emit_ok) begin
              DataNext   <= 1'b1;
              transmit   <= 1'b1;
              hold_q     <= DataVal;
              pay_cnt_q  <= pay_cnt_q + 8'd1;
              idle_cnt_q <= 16'h0000;
              ret_q      <= (pay_cnt_q + 8'd1 == FrameLen) ? StTail : StFetch;
`ifdef TRACE_FRAME_CRC_EN
              crc_q      <= crc_step(crc_q, DataVal);
`endif
              if (is_special(DataVal)) begin
                tx_byte <= ESC;
                state_q <= StEsc2;
              end else begin
                tx_byte <= DataVal;
                if (pay_cnt_q + 8'd1 == FrameLen) state_q <= StTail;
              end
            end
          end else if (idle_cnt_q != 16'hFFFF) begin
            idle_cnt_q <= idle_cnt_q + 16'd1;
          end
        end
        StEsc2: begin
          if (emit_ok) begin
            transmit <= 1'b1;
            tx_byte  <= hold_q ^ 8'h20;
            state_q  <= ret_q;
          end
        end
`ifdef TRACE_FRAME_CRC_EN
        StTail: state_q <= StCrcHi;
        StCrcHi: begin
          if (emit_ok) begin
            transmit <= 1'b1;
            if (is_special(crc_q[15:8])) begin
              tx_byte <= ESC;
              hold_q  <= crc_q[15:8];
              ret_q   <= StCrcLo;
              state_q <= StEsc2;
            end else begin
              tx_byte <= crc_q[15:8];
              state_q <= StCrcLo;
            end
          end
        end
        StCrcLo: begin
          if (emit_ok) begin
            transmit <= 1'b1;
            if (is_special(crc_q[7:0])) begin
              tx_byte <= ESC;
              hold_q  <= crc_q[7:0];
              ret_q   <= StClose;
              state_q <= StEsc2;
            end else begin
              tx_byte <= crc_q[7:0];
              state_q <= StClose;
            end
          end
        end
`else
        StTail: state_q <= StClose;
`endif
        StClose: begin
          if (emit_ok) begin
            transmit  <= 1'b1;
            tx_byte   <= FLAG;
            frame_cnt <= frame_cnt + 16'd1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_frame_encoder.sv
// Self-checking bench for trace_frame_encoder: a byte-stream model of framing, stuffing and CRC
// is compared against every UART load, plus literal pins of the model on known sequences.
module tb_trace_frame_encoder;

  localparam int unsigned FrameLen    = 16;
  localparam int unsigned IdleTimeout = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        DataAvail = 1'b0;
  logic [7:0]  DataVal = 8'h00;
  logic        tx_free = 1'b0;
  logic        DataNext;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        busy;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  trace_frame_encoder #(
    .FRAME_LEN   (FrameLen),
    .IDLE_TIMEOUT(IdleTimeout)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .DataAvail(DataAvail),
    .DataVal  (DataVal),
    .DataNext (DataNext),
    .tx_free  (tx_free),
    .transmit (transmit),
    .tx_byte  (tx_byte),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  logic [7:0]  up_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  tx_log[$];
  logic [7:0]  batch[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          tx_n = 0;
  int          dn_n = 0;
  int          frames_exp = 0;
  int          last_dn_cyc = 0;
  int          gap = -1;
  bit          gap_pend = 1'b0;
  bit          prev_tx = 1'b0;
  bit          rand_free = 1'b0;
  logic [15:0] last_crc = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_stuffed(input logic [7:0] b);
    if (b == 8'h7E || b == 8'h7D) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(b ^ 8'h20);
    end else begin
      exp_q.push_back(b);
    end
  endtask

  // Splits the batch into FrameLen-sized frames; the last partial frame closes on idle timeout.
  task automatic send_batch();
    int          i;
    int          n;
    logic [15:0] crc;
    logic        fb;
    i = 0;
    while (i < batch.size()) begin
      n = (batch.size() - i > FrameLen) ? FrameLen : batch.size() - i;
      crc = 16'hFFFF;
      exp_q.push_back(8'h7E);
      for (int k = 0; k < n; k++) begin
        push_stuffed(batch[i + k]);
        for (int b = 7; b >= 0; b--) begin
          fb  = crc[15] ^ batch[i + k][b];
          crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
      end
`ifdef TRACE_FRAME_CRC_EN
      push_stuffed(crc[15:8]);
      push_stuffed(crc[7:0]);
`endif
      exp_q.push_back(8'h7E);
      last_crc = crc;
      frames_exp++;
      i += n;
    end
    foreach (batch[j]) up_q.push_back(batch[j]);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((up_q.size() != 0 || exp_q.size() != 0 || busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done_in_time"}, 32'(t < 20000), 1);
    repeat (5) @(negedge clk);
    check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(frames_exp));
    check({name, "_busy_low"}, 32'(busy), 0);
    check({name, "_stream_left"}, 32'(exp_q.size()), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_DataNext"}, 32'(DataNext), 0);
    check({name, "_transmit"}, 32'(transmit), 0);
    check({name, "_tx_byte"}, 32'(tx_byte), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_frame_cnt"}, 32'(frame_cnt), 0);
  endtask

  // Upstream source, UART sink and per-cycle compare, all sampled at the falling edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (transmit) begin
        tx_n++;
        tx_log.push_back(tx_byte);
        check("tx_free_at_load", 32'(tx_free), 1);
        check("tx_spacing", 32'(prev_tx), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got %02h want no transmit", tx_byte);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'(tx_byte), 32'(e));
        end
      end
      if (DataNext) begin
        dn_n++;
        check("datanext_with_tx", 32'(transmit), 1);
        check("datanext_busy", 32'(busy), 1);
        if (up_q.size() != 0) void'(up_q.pop_front());
        last_dn_cyc = cyc;
        gap_pend = 1'b1;
      end else if (transmit && gap_pend) begin
        gap = cyc - last_dn_cyc;
        gap_pend = 1'b0;
      end
      prev_tx = transmit;
      tx_free = rand_free ? ($urandom_range(0, 1) == 1) : 1'b1;
      DataAvail = (up_q.size() != 0);
      DataVal = DataAvail ? up_q[0] : 8'h00;
    end
  end

  initial begin
    int base;
    int dn_base;
    int fc_base;
    int t;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain bytes.
    base = tx_log.size();
    dn_base = dn_n;
    batch = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_batch();
    wait_done("plain");
    check("plain_open", 32'(tx_log[base]), 32'h7E);
    check("plain_b0", 32'(tx_log[base + 1]), 32'h01);
    check("plain_b3", 32'(tx_log[base + 4]), 32'h04);
    check("plain_close", 32'(tx_log[tx_log.size() - 1]), 32'h7E);
    check("plain_datanext", 32'(dn_n - dn_base), 4);
    check("plain_frames", 32'(frame_cnt), 1);

    // Flag and escape bytes are stuffed.
    base = tx_log.size();
    batch = '{8'h7E, 8'h7D, 8'h41, 8'h20};
    send_batch();
    wait_done("stuff");
    check("stuff_0", 32'(tx_log[base]), 32'h7E);
    check("stuff_1", 32'(tx_log[base + 1]), 32'h7D);
    check("stuff_2", 32'(tx_log[base + 2]), 32'h5E);
    check("stuff_3", 32'(tx_log[base + 3]), 32'h7D);
    check("stuff_4", 32'(tx_log[base + 4]), 32'h5D);
    check("stuff_5", 32'(tx_log[base + 5]), 32'h41);
    check("stuff_6", 32'(tx_log[base + 6]), 32'h20);

    // CRC check string.
    base = tx_log.size();
    batch = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_batch();
    check("model_crc_check_string", 32'(last_crc), 32'h29B1);
    wait_done("crc");
`ifdef TRACE_FRAME_CRC_EN
    check("crc_hi", 32'(tx_log[base + 10]), 32'h29);
    check("crc_lo", 32'(tx_log[base + 11]), 32'hB1);
`endif
    check("crc_close", 32'(tx_log[tx_log.size() - 1]), 32'h7E);

    // Early close on idle, and no spontaneous frame afterwards.
    gap = -1;
    batch = '{8'hAA, 8'hBB};
    send_batch();
    wait_done("idle");
    check("idle_gap_min", 32'(gap >= int'(IdleTimeout)), 1);
    check("idle_gap_max", 32'(gap <= int'(IdleTimeout) + 8), 1);
    base = tx_n;
    repeat (60) @(negedge clk);
    check("idle_no_reopen", 32'(tx_n - base), 0);
    check("idle_busy", 32'(busy), 0);

    // Random payload under a toggling tx_free.
    fc_base = frame_cnt;
    dn_base = dn_n;
    rand_free = 1'b1;
    batch.delete();
    for (int i = 0; i < 100; i++) batch.push_back(8'($urandom_range(0, 255)));
    batch[10] = 8'h7E;
    batch[31] = 8'h7D;
    send_batch();
    wait_done("random");
    rand_free = 1'b0;
    check("random_frames", 32'(frame_cnt - fc_base), 7);
    check("random_datanext", 32'(dn_n - dn_base), 100);

    // Reset mid-payload abandons the frame.
    base = tx_log.size();
    batch = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_batch();
    t = 0;
    while (tx_n < base + 2 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("midreset_reached", 32'(t < 1000), 1);
    check("midreset_open", 32'(tx_log[base]), 32'h7E);
    check("midreset_b0", 32'(tx_log[base + 1]), 32'h01);
    @(negedge clk);
    rst = 1'b1;
    up_q.delete();
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;
    frames_exp = 0;
    repeat (3) @(negedge clk);
    base = tx_log.size();
    batch = '{8'h55, 8'h66};
    send_batch();
    wait_done("after_reset");
    check("after_reset_open", 32'(tx_log[base]), 32'h7E);
    check("after_reset_b0", 32'(tx_log[base + 1]), 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
